// File: rtl/fetch_pkg.sv
// Shared widths, FSM state type and queue entry layout for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEP   = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              zero;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Output stream of the fetch sequencer: valid/ready handshake plus head word.
//   master (fetch_unit): drives outValid, outInstr, outPc, outZero; reads outReady
//   slave  (consumer)  : reads the head fields; drives outReady
interface fetch_if;
  import fetch_pkg::*;

  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outInstr;
  logic [ADDR_W-1:0] outPc;
  logic              outZero;

  modport master (output outValid, output outInstr, output outPc, output outZero,
                  input outReady);
  modport slave  (input outValid, input outInstr, input outPc, input outZero,
                  output outReady);
endinterface

// File: rtl/fetch_fifo.sv
// Circular DEPTH-entry queue of fetched words.
//   clk, rst  : clock, async active-high reset
//   push_i    : write wdata_i at the tail (caller guarantees not full)
//   pop_i     : consumer accepts head (ignored when empty)
//   flush_i   : drop all entries, clear pointers and count
//   head_o    : head entry, or the last presented head while empty
//   valid_o   : queue not empty
//   count_o   : occupancy 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     hold_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;

  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
  assign pop_ok  = pop_i & valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : hold_q;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok) rd_q <= rd_q + PTR_W'(1);
      unique case ({push_i, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: it is only observed once written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  // Keeps the head fields stable after the queue drains or is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold_q <= '0;
    else if (valid_o) hold_q <= mem_q[rd_q];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer in front of a one-cycle registered word memory.
//   clk, rst   : clock, async active-high reset
//   dir        : byte address to the memory (current pc)
//   memData    : word returned by the memory one cycle after dir
//   memZero    : zero flag returned alongside memData
//   branchTake : redirect request, highest priority
//   branchDir  : redirect target (low two bits ignored)
//   deq        : output stream (valid/ready, head word, pc, zero flag)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] memData,
  input  logic              memZero,
  input  logic              branchTake,
  input  logic [ADDR_W-1:0] branchDir,
  fetch_if.master           deq
);

  localparam int unsigned CR_W = CNT_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic [CNT_W-1:0]  count;
  logic              head_valid, pop, push, credit_ok, issue;
  fetch_entry_t      push_entry, head;
  logic              unused_bdir_lsbs;

  assign unused_bdir_lsbs = ^branchDir[1:0];

  assign dir  = pc_q;
  assign pop  = head_valid & deq.outReady;
  // The tag marks a word now sitting on the memory output; a branch discards it.
  assign push = tag_vld_q & ~branchTake;
  assign push_entry = '{addr: tag_addr_q, zero: memZero, data: memData};

  // Room for one more word once queued, in-flight and departing words are counted.
  assign credit_ok = (CR_W'(count) + CR_W'(tag_vld_q)) < (CR_W'(DEPTH) + CR_W'(pop));

  // Next-state, issue and redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_vld_d  = 1'b0;
    tag_addr_d = tag_addr_q;
    issue      = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (credit_ok) issue = 1'b1;
        else           state_d = HOLD;
      end
      HOLD: begin
        if (credit_ok) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    if (issue) begin
      pc_d       = pc_q + ADDR_W'(STEP);
      tag_vld_d  = 1'b1;
      tag_addr_d = pc_q;
    end
    if (branchTake) begin
      pc_d      = {branchDir[ADDR_W-1:2], 2'b00};
      tag_vld_d = 1'b0;
      state_d   = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (branchTake),
    .wdata_i (push_entry),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (count)
  );

  assign deq.outValid = head_valid;
  assign deq.outInstr = head.data;
  assign deq.outPc    = head.addr;
  assign deq.outZero  = head.zero;

endmodule
